// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory store responder: FSM states,
// default mailbox addresses and status-word layout.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [31:0] DEF_PASS_ADDR    = 32'd84;
   localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
   localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd80;
   localparam logic [31:0] DEF_STATUS_ADDR  = 32'h0000_FFFC;

   localparam int unsigned STAT_DONE_BIT    = 0;
   localparam int unsigned STAT_PASS_BIT    = 1;
   localparam int unsigned STAT_FAIL_BIT    = 2;
   localparam int unsigned STAT_CNT_LSB     = 3;
   localparam int unsigned STAT_CNT_W       = 13;
   localparam int unsigned STAT_TIMEOUT_BIT = 31;

   // Pack the verdict flags and low counter bits into the read-only status word.
   function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                               input logic        fail_f,
                                               input logic        pass_f,
                                               input logic        done_f,
                                               input logic        timeout_f);
      logic [31:0] w;
      w = 32'h0;
      w[STAT_DONE_BIT]                 = done_f;
      w[STAT_PASS_BIT]                 = pass_f;
      w[STAT_FAIL_BIT]                 = fail_f;
      w[STAT_CNT_LSB +: STAT_CNT_W]    = cnt[STAT_CNT_W-1:0];
      w[STAT_TIMEOUT_BIT]              = timeout_f;
      return w;
   endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// DEPTH x 32 single-port RAM: asynchronous read, synchronous write.
module dmem_ram_sp #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Same-cycle read returns the pre-write word.
   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_store_responder.sv
// Data-memory responder with a hardware self-check mailbox and sticky verdict.
// Optional DMEM_WATCHDOG_EN adds a 20-bit no-verdict timeout that forces FAIL.
module dmem_store_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH        = 64,
   parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
   parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
   parameter bit          CHECK_STRICT = 1'b1,
   parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [15:0] store_cnt,
   output logic [31:0] last_addr
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_t        state, state_nxt;
   logic          active_c, is_status_c, misaligned_c, illegal_c, bad_pass_c;
   logic          store_fail_c, take_c, pass_hit_c, fail_hit_c, ram_we_c;
   logic          wd_expire_c, timeout;
   logic [AW-1:0] idx_c;
   logic [31:0]   ram_rdata_c;

   assign idx_c        = addr[AW+1:2];
   assign active_c     = (state == ST_IDLE) || (state == ST_RUN);
   assign is_status_c  = (addr == STATUS_ADDR);
   assign misaligned_c = (addr[1:0] != 2'b00);
   assign illegal_c    = CHECK_STRICT && (addr != SCRATCH_ADDR) && (addr != PASS_ADDR);
   assign bad_pass_c   = (addr == PASS_ADDR) && (wdata != PASS_DATA);
   assign store_fail_c = misaligned_c || illegal_c || bad_pass_c;

   // Lenient builds silently drop stores to the status word.
   assign take_c     = we && active_c && !(!CHECK_STRICT && is_status_c);
   assign fail_hit_c = take_c && store_fail_c;
   assign pass_hit_c = take_c && !store_fail_c && (addr == PASS_ADDR);
   assign ram_we_c   = take_c && !store_fail_c;

`ifdef DMEM_WATCHDOG_EN
   logic [19:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt  <= 20'h0;
         timeout <= 1'b0;
      end else begin
         if (active_c) wd_cnt <= wd_cnt + 20'd1;
         if (wd_expire_c && !pass_hit_c && !fail_hit_c) timeout <= 1'b1;
      end
   end

   assign wd_expire_c = active_c && (wd_cnt == 20'hFFFFF);
`else
   assign wd_expire_c = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // A store verdict outranks the watchdog in the same cycle.
   always_comb begin
      state_nxt = state;
      if (pass_hit_c)                          state_nxt = ST_PASS;
      else if (fail_hit_c || wd_expire_c)      state_nxt = ST_FAIL;
      else if (take_c && (state == ST_IDLE))   state_nxt = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         store_cnt <= 16'h0;
         last_addr <= 32'h0;
      end else begin
         done <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL);
         pass <= (state_nxt == ST_PASS);
         fail <= (state_nxt == ST_FAIL);
         if (take_c) begin
            last_addr <= addr;
            if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
         end
      end
   end

   dmem_ram_sp #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_c),
      .idx   (idx_c),
      .wdata (wdata),
      .rdata (ram_rdata_c)
   );

   assign rdata = is_status_c ? status_word(store_cnt, fail, pass, done, timeout)
                              : ram_rdata_c;

endmodule

// File: tb/tb_dmem_store_responder.sv
// Directed bench: a strict and a lenient responder share one stimulus stream.
module tb_dmem_store_responder;

   logic        clk, rst, we;
   logic [31:0] addr, wdata;

   logic [31:0] d_rdata, d_last, n_rdata, n_last;
   logic        d_done, d_pass, d_fail, n_done, n_pass, n_fail;
   logic [15:0] d_cnt, n_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_store_responder dut (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
      .rdata(d_rdata), .done(d_done), .pass(d_pass), .fail(d_fail),
      .store_cnt(d_cnt), .last_addr(d_last)
   );

   dmem_store_responder #(.CHECK_STRICT(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
      .rdata(n_rdata), .done(n_done), .pass(n_pass), .fail(n_fail),
      .store_cnt(n_cnt), .last_addr(n_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      we  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if (d_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0h exp=0", d_done); end
      n_cmp++; if (d_fail !== 1'b0 || d_pass !== 1'b0) begin n_bad++; $display("FAIL reset_pf got=%0h%0h exp=00", d_pass, d_fail); end
      n_cmp++; if (d_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got=%0h exp=0", d_cnt); end
      n_cmp++; if (d_last !== 32'h0) begin n_bad++; $display("FAIL reset_last got=%0h exp=0", d_last); end
      n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%0h exp=0", d_rdata); end
   endtask

   task automatic test_pass();
      store(32'd80, 32'd3);
      n_cmp++; if (d_done !== 1'b0 || d_cnt !== 16'd1 || d_last !== 32'd80) begin n_bad++; $display("FAIL pass_first got=%0h/%0h/%0h exp=0/1/50", d_done, d_cnt, d_last); end
      store(32'd84, 32'd7);
      n_cmp++; if ({d_done, d_pass, d_fail} !== 3'b110) begin n_bad++; $display("FAIL pass_flags got=%0b exp=110", {d_done, d_pass, d_fail}); end
      n_cmp++; if (d_cnt !== 16'd2 || d_last !== 32'd84) begin n_bad++; $display("FAIL pass_cnt_last got=%0h/%0h exp=2/54", d_cnt, d_last); end
      addr = 32'd84; #1;
      n_cmp++; if (d_rdata !== 32'd7) begin n_bad++; $display("FAIL pass_ram84 got=%0h exp=7", d_rdata); end
      addr = 32'd80; #1;
      n_cmp++; if (d_rdata !== 32'd3) begin n_bad++; $display("FAIL pass_ram80 got=%0h exp=3", d_rdata); end
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if (d_rdata !== 32'h13) begin n_bad++; $display("FAIL pass_status got=%0h exp=13", d_rdata); end
   endtask

   task automatic test_bad_pass();
      do_reset();
      store(32'd84, 32'd5);
      n_cmp++; if ({d_done, d_pass, d_fail} !== 3'b101 || d_cnt !== 16'd1) begin n_bad++; $display("FAIL badpass_flags got=%0b/%0h exp=101/1", {d_done, d_pass, d_fail}, d_cnt); end
      addr = 32'd84; #1;
      n_cmp++; if (d_rdata !== 32'd7) begin n_bad++; $display("FAIL badpass_ram84 got=%0h exp=7", d_rdata); end
      store(32'd80, 32'd9);
      n_cmp++; if (d_cnt !== 16'd1 || d_last !== 32'd84) begin n_bad++; $display("FAIL frozen_cnt_last got=%0h/%0h exp=1/54", d_cnt, d_last); end
      addr = 32'd80; #1;
      n_cmp++; if (d_rdata !== 32'd3) begin n_bad++; $display("FAIL frozen_ram80 got=%0h exp=3", d_rdata); end
   endtask

   task automatic test_strict();
      do_reset();
      store(32'd40, 32'd1);
      n_cmp++; if (d_fail !== 1'b1 || d_last !== 32'd40) begin n_bad++; $display("FAIL strict_fail got=%0h/%0h exp=1/28", d_fail, d_last); end
      n_cmp++; if (n_done !== 1'b0 || n_fail !== 1'b0 || n_cnt !== 16'd1) begin n_bad++; $display("FAIL lenient_run got=%0h/%0h/%0h exp=0/0/1", n_done, n_fail, n_cnt); end
      addr = 32'd40; #1;
      n_cmp++; if (n_rdata !== 32'd1) begin n_bad++; $display("FAIL lenient_ram40 got=%0h exp=1", n_rdata); end
   endtask

   task automatic test_misaligned();
      do_reset();
      store(32'd82, 32'd1);
      n_cmp++; if (d_fail !== 1'b1 || n_fail !== 1'b1) begin n_bad++; $display("FAIL misalign_fail got=%0h/%0h exp=1/1", d_fail, n_fail); end
      n_cmp++; if (d_last !== 32'd82 || d_cnt !== 16'd1) begin n_bad++; $display("FAIL misalign_last got=%0h/%0h exp=52/1", d_last, d_cnt); end
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if (d_rdata !== 32'h0000_000D || n_rdata !== 32'h0000_000D) begin n_bad++; $display("FAIL misalign_status got=%0h/%0h exp=d", d_rdata, n_rdata); end
   endtask

   task automatic test_reset_collision();
      rst = 1'b1; we = 1'b1; addr = 32'd84; wdata = 32'd7;
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0;
      n_cmp++; if (d_done !== 1'b0 || d_cnt !== 16'd0 || d_last !== 32'd0) begin n_bad++; $display("FAIL rst_collide got=%0h/%0h/%0h exp=0/0/0", d_done, d_cnt, d_last); end
      store(32'd84, 32'd7);
      n_cmp++; if (d_pass !== 1'b1 || d_cnt !== 16'd1) begin n_bad++; $display("FAIL idle_to_pass got=%0h/%0h exp=1/1", d_pass, d_cnt); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if ({d_done, d_pass, d_fail} !== 3'b000 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_from_pass got=%0b/%0h exp=000/0", {d_done, d_pass, d_fail}, d_rdata); end
   endtask

   task automatic test_status_store();
      store(32'h0000_FFFC, 32'd5);
      n_cmp++; if (d_fail !== 1'b1) begin n_bad++; $display("FAIL status_store_strict got=%0h exp=1", d_fail); end
      n_cmp++; if (n_done !== 1'b0 || n_cnt !== 16'd0 || n_last !== 32'd0) begin n_bad++; $display("FAIL status_store_lenient got=%0h/%0h/%0h exp=0/0/0", n_done, n_cnt, n_last); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      store(32'd100, 32'h11);
      we = 1'b1; addr = 32'd100; wdata = 32'h22; #1;
      n_cmp++; if (n_rdata !== 32'h11) begin n_bad++; $display("FAIL rdw_old got=%0h exp=11", n_rdata); end
      @(posedge clk); #1;
      we = 1'b0;
      n_cmp++; if (n_rdata !== 32'h22 || n_cnt !== 16'd2) begin n_bad++; $display("FAIL rdw_new got=%0h/%0h exp=22/2", n_rdata, n_cnt); end
      addr = 32'd356; #1;
      n_cmp++; if (n_rdata !== 32'h22) begin n_bad++; $display("FAIL alias_wrap got=%0h exp=22", n_rdata); end
   endtask

   task automatic test_watchdog();
      do_reset();
`ifdef DMEM_WATCHDOG_EN
      repeat ((1 << 20) - 1) @(posedge clk);
      #1;
      n_cmp++; if (d_fail !== 1'b0) begin n_bad++; $display("FAIL wd_early got=%0h exp=0", d_fail); end
      @(posedge clk); #1;
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if (d_fail !== 1'b1 || d_rdata !== 32'h8000_0005) begin n_bad++; $display("FAIL wd_trip got=%0h/%0h exp=1/80000005", d_fail, d_rdata); end
`else
      repeat (300) @(posedge clk);
      #1;
      addr = 32'h0000_FFFC; #1;
      n_cmp++; if (d_fail !== 1'b0 || d_done !== 1'b0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL no_wd got=%0h/%0h/%0h exp=0/0/0", d_fail, d_done, d_rdata); end
`endif
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
      test_reset();
      test_pass();
      test_bad_pass();
      test_strict();
      test_misaligned();
      test_reset_collision();
      test_status_store();
      test_back_to_back();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
